// File: rtl/console_tx_ctrl.sv
// console_tx_ctrl: buffers the CPU console byte stream in a small FIFO and
// serialises it onto a UART TX pin as contiguous 8N1 frames. After a trap the
// block refuses new bytes, finishes sending what is queued, then raises a
// sticky drained flag.
module console_tx_ctrl #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       trap,
  output logic       uart_tx,
  output logic       busy,
  output logic       drained,
  output logic [7:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage; pointers carry one extra wrap bit
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;

  // serialiser state
  state_t        r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  // trap bookkeeping
  logic          r_trap_latched;
  logic          r_drained;
  logic [7:0]    r_drop_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign wr_ready  = !w_full && !r_trap_latched;
  assign w_push    = wr_valid && wr_ready;
  assign w_bit_end = (r_bit_cnt == CNT_LAST);
  // The head is taken either from idle or at the very end of a stop bit, so
  // back-to-back frames leave no gap on the line.
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  assign busy      = !w_empty || (r_state != S_IDLE);
  assign uart_tx   = r_tx;
  assign drained   = r_drained;
  assign drop_cnt  = r_drop_cnt;

  // FIFO data array write; contents need no reset because pointers gate them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= wr_data;
    end
  end

  // FIFO pointer update; a reset discards whatever is queued
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // frame sequencer; the line level is registered one cycle behind the state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_bit_cnt <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_idx     <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // trap latch, sticky drained flag and saturating refused-write counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_trap_latched <= 1'b0;
      r_drained      <= 1'b0;
      r_drop_cnt     <= 8'd0;
    end else begin
      r_trap_latched <= r_trap_latched | trap;
      r_drained      <= r_drained |
                        (r_trap_latched && w_empty && (r_state == S_IDLE));
      if (r_trap_latched && wr_valid && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

endmodule
